shifter_load_sched: RTL and testbench

SHIFTER_LOAD_SCHED -- requirements
Module: shifter_load_sched

---
 rtl/shifter_load_sched_pkg.sv | 41 ++++
 rtl/shifter_word_fifo.sv | 69 ++++++
 rtl/shifter_load_sched.sv | 184 ++++++++++++++++++
 tb/tb_shifter_load_sched.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_load_sched_pkg.sv
// Shared definitions for the shifter load scheduler.
//   - sched_state_t : scheduler FSM state encoding (exposed on state_dbg)
//   - REZ_*         : video resolution codes on the rez input
//   - DEFAULT_*     : default slot period, load pulse width and FIFO depth
//   - pix_en_for()  : pixel clock enable cadence for a resolution and slot
package shifter_load_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_LOADING = 2'd2,
    ST_HOLD    = 2'd3
  } sched_state_t;

  localparam logic [1:0] REZ_LOW     = 2'd0;
  localparam logic [1:0] REZ_MID     = 2'd1;
  localparam logic [1:0] REZ_HIGH    = 2'd2;
  localparam logic [1:0] REZ_MID_ALT = 2'd3;

  localparam int DEFAULT_LOAD_PERIOD = 16;
  localparam int DEFAULT_LOAD_WIDTH  = 4;
  localparam int DEFAULT_FIFO_DEPTH  = 4;
  localparam int WORD_W              = 16;

  // Low rez shifts every 4th clk32, mid every 2nd, high every cycle.
  // Code 3 is not a real mode and is treated as mid.
  function automatic logic pix_en_for(input logic [1:0] rez_sel,
                                      input logic [1:0] slot_lsbs);
    logic en;
    en = 1'b0;
    case (rez_sel)
      REZ_LOW:     en = (slot_lsbs == 2'b11);
      REZ_MID:     en = slot_lsbs[0];
      REZ_HIGH:    en = 1'b1;
      REZ_MID_ALT: en = slot_lsbs[0];
      default:     en = 1'b0;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/shifter_word_fifo.sv
// Synchronous word FIFO feeding the shifter load scheduler.
// Ports:
//   clk32, reset : clock and synchronous active-high reset
//   flush        : empties the FIFO on the next edge, overriding push/pop
//   push, wr_data: write request (ignored while full)
//   pop, rd_data : read request (ignored while empty); rd_data shows the head
//   full, empty  : derived from the registered occupancy count
//   count        : registered occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap without compare logic.
module shifter_word_fifo
  import shifter_load_sched_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int WIDTH = WORD_W
) (
  input  logic                     clk32,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rd_data = mem[rd_ptr];

  // Both qualifiers use the registered count, so a word written this cycle
  // can never be read out in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk32) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage is not reset; the pointers alone define valid contents.
  always_ff @(posedge clk32) begin
    if (do_push && !flush && !reset) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/shifter_load_sched.sv
// Shifter load scheduler: buffers memory words and hands one to the video
// shifter per load slot, and generates the pixel clock enable for the
// current resolution.
// Ports:
//   clk32, reset          : sole clock, synchronous active-high reset
//   rez[1:0]              : resolution (0 low, 1 mid, 2 high, 3 as mid),
//                           adopted only at the last slot of a period
//   de                    : display enable, sampled at the last slot
//   flush                 : frame-start pulse; empties FIFO, idles FSM,
//                           drops load, clears underrun
//   din/din_valid/din_ready : word stream in. A word transfers on a rising
//                           edge where din_valid and din_ready are both high;
//                           din_ready is simply "FIFO not full" and does not
//                           depend on din_valid.
//   pix_clk_en            : pixel clock enable
//   load                  : word-load strobe, LOAD_WIDTH cycles wide
//   dout[15:0]            : word for the shifter; shows the popped word from
//                           the pop cycle onward, one cycle before load rises
//   underrun              : sticky, set when a load slot finds the FIFO empty
//   state_dbg[1:0]        : current scheduler state (sched_state_t)
//   fifo_count            : current FIFO occupancy
//   underrun_cnt[7:0]     : saturating skipped-slot count, only present when
//                           SHIFTER_LOAD_SCHED_UNDERRUN_CNT_EN is defined
// LOAD_PERIOD must be at least 4 and exceed LOAD_WIDTH + 1.
module shifter_load_sched
  import shifter_load_sched_pkg::*;
#(
  parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH,
  parameter int LOAD_PERIOD = DEFAULT_LOAD_PERIOD,
  parameter int LOAD_WIDTH  = DEFAULT_LOAD_WIDTH
) (
  input  logic                          clk32,
  input  logic                          reset,
  input  logic [1:0]                    rez,
  input  logic                          de,
  input  logic                          flush,
  input  logic [15:0]                   din,
  input  logic                          din_valid,
  output logic                          din_ready,
  output logic                          pix_clk_en,
  output logic                          load,
  output logic [15:0]                   dout,
  output logic                          underrun,
  output logic [1:0]                    state_dbg,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef SHIFTER_LOAD_SCHED_UNDERRUN_CNT_EN
  ,
  output logic [7:0]                    underrun_cnt
`endif
);

  localparam int SW = $clog2(LOAD_PERIOD);
  localparam int WW = (LOAD_WIDTH > 1) ? $clog2(LOAD_WIDTH) : 1;
  localparam logic [SW-1:0] SLOT_LAST  = SW'(LOAD_PERIOD - 1);
  localparam logic [WW-1:0] WIDTH_LAST = WW'(LOAD_WIDTH - 1);

  logic [SW-1:0] slot;
  logic [SW-1:0] slot_nxt;
  logic [1:0]    rez_q;
  logic [1:0]    rez_nxt;
  logic          pix_q;
  sched_state_t  state;
  logic [WW-1:0] load_cnt;
  logic          load_q;
  logic          underrun_q;
  logic [15:0]   dout_q;

  logic [15:0]   fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic          slot_first;
  logic          slot_last;
  logic          slot_wait;
  logic          skip;

  shifter_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk32   (clk32),
    .reset   (reset),
    .flush   (flush),
    .push    (din_valid),
    .wr_data (din),
    .pop     (fifo_pop),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign slot_first = (slot == '0);
  assign slot_last  = (slot == SLOT_LAST);
  assign slot_wait  = (state == ST_ARMED) || (state == ST_HOLD);

  // Slot 0 decision: take a word if one is buffered, otherwise skip the slot.
  assign fifo_pop = slot_first && slot_wait && !fifo_empty && !flush && !reset;
  assign skip     = slot_first && slot_wait &&  fifo_empty && !flush && !reset;

  always_comb begin
    slot_nxt = slot_last ? '0 : slot + SW'(1);
    rez_nxt  = slot_last ? rez : rez_q;
  end

  // Slot counter and resolution; pix_clk_en is registered from the values
  // the counter and rez_q take on this edge, so it lines up with slot.
  always_ff @(posedge clk32) begin
    if (reset) begin
      slot  <= '0;
      rez_q <= REZ_LOW;
      pix_q <= 1'b0;
    end else begin
      slot  <= slot_nxt;
      rez_q <= rez_nxt;
      pix_q <= pix_en_for(rez_nxt, slot_nxt[1:0]);
    end
  end

  always_ff @(posedge clk32) begin
    if (reset) begin
      state      <= ST_IDLE;
      load_cnt   <= '0;
      load_q     <= 1'b0;
      underrun_q <= 1'b0;
      dout_q     <= '0;
    end else if (flush) begin
      state      <= ST_IDLE;
      load_cnt   <= '0;
      load_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      if (fifo_pop) dout_q <= fifo_rdata;
      if (skip)     underrun_q <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (slot_last && de) state <= ST_ARMED;
        end
        ST_ARMED, ST_HOLD: begin
          if (fifo_pop) begin
            state    <= ST_LOADING;
            load_q   <= 1'b1;
            load_cnt <= '0;
          end else if (slot_last && !de) begin
            state <= ST_IDLE;
          end
        end
        ST_LOADING: begin
          if (load_cnt == WIDTH_LAST) begin
            state  <= ST_HOLD;
            load_q <= 1'b0;
          end else begin
            load_cnt <= load_cnt + WW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SHIFTER_LOAD_SCHED_UNDERRUN_CNT_EN
  logic [7:0] ucnt_q;

  always_ff @(posedge clk32) begin
    if (reset || flush) begin
      ucnt_q <= '0;
    end else if (skip && (ucnt_q != 8'hFF)) begin
      ucnt_q <= ucnt_q + 8'd1;
    end
  end

  assign underrun_cnt = ucnt_q;
`endif

  // During the pop cycle the head word is forwarded so dout is settled a
  // full cycle before load rises; afterwards the registered copy holds it.
  assign dout       = fifo_pop ? fifo_rdata : dout_q;
  assign din_ready  = !fifo_full;
  assign pix_clk_en = pix_q;
  assign load       = load_q;
  assign underrun   = underrun_q;
  assign state_dbg  = state;

endmodule

// File: tb/tb_shifter_load_sched.sv
// Bench for shifter_load_sched: directed scenarios followed by random
// traffic, every cycle compared against a slot-level behavioural model.
module tb_shifter_load_sched;
  import shifter_load_sched_pkg::*;

  localparam int DEPTH = 4;
  localparam int P     = 16;
  localparam int W     = 4;

  // ---------------- clock / reset ----------------
  logic clk32 = 1'b0;
  always #5 clk32 = ~clk32;

  logic        reset, de, flush, din_valid;
  logic [1:0]  rez;
  logic [15:0] din;
  logic        din_ready, pix_clk_en, load, underrun;
  logic [15:0] dout;
  logic [1:0]  state_dbg;
  logic [2:0]  fifo_count;
`ifdef SHIFTER_LOAD_SCHED_UNDERRUN_CNT_EN
  logic [7:0]  underrun_cnt;
`endif

  shifter_load_sched #(
    .FIFO_DEPTH  (DEPTH),
    .LOAD_PERIOD (P),
    .LOAD_WIDTH  (W)
  ) dut (
    .clk32      (clk32),
    .reset      (reset),
    .rez        (rez),
    .de         (de),
    .flush      (flush),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .pix_clk_en (pix_clk_en),
    .load       (load),
    .dout       (dout),
    .underrun   (underrun),
    .state_dbg  (state_dbg),
    .fifo_count (fifo_count)
`ifdef SHIFTER_LOAD_SCHED_UNDERRUN_CNT_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [15:0] exp_q[$];     // words the FIFO should hold, head first
  int          m_slot;
  int          m_rez;
  bit          m_active;     // de was high at the last slot boundary
  int          m_load_left;  // cycles of load still to show
  logic [15:0] m_word;
  bit          m_underrun;
  int          m_ucnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit exp_pix(input int rz, input int s);
    if (rz == 0) return (s % 4) == 3;
    if (rz == 2) return 1'b1;
    return (s % 2) == 1;
  endfunction

  function automatic bit m_pop_now();
    return !reset && !flush && m_active && m_load_left == 0 && m_slot == 0 && exp_q.size() > 0;
  endfunction

  task automatic model_update();
    bit pop, skip, push;
    if (reset) begin
      m_slot = 0; m_rez = 0; m_active = 0; m_load_left = 0;
      exp_q.delete(); m_word = '0; m_underrun = 0; m_ucnt = 0;
      return;
    end
    pop  = m_pop_now();
    skip = !flush && m_active && m_slot == 0 && exp_q.size() == 0;
    push = din_valid && exp_q.size() < DEPTH && !flush;
    if (flush) begin
      exp_q.delete();
      m_load_left = 0; m_underrun = 0; m_ucnt = 0; m_active = 0;
    end else begin
      if (pop) m_word = exp_q.pop_front();
      if (push) exp_q.push_back(din);
      if (pop) m_load_left = W;
      else if (m_load_left > 0) m_load_left--;
      if (skip) begin
        m_underrun = 1;
        if (m_ucnt < 255) m_ucnt++;
      end
      if (m_slot == P - 1) m_active = de;
    end
    if (m_slot == P - 1) begin
      m_rez = rez;
      m_slot = 0;
    end else begin
      m_slot++;
    end
  endtask

  task automatic compare_all();
    check("pix_clk_en", pix_clk_en, exp_pix(m_rez, m_slot));
    check("load", load, m_load_left > 0);
    check("dout", dout, m_pop_now() ? exp_q[0] : m_word);
    check("din_ready", din_ready, exp_q.size() < DEPTH);
    check("underrun", underrun, m_underrun);
    check("fifo_count", fifo_count, exp_q.size());
`ifdef SHIFTER_LOAD_SCHED_UNDERRUN_CNT_EN
    check("underrun_cnt", underrun_cnt, m_ucnt);
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk32);
    if (!reset) compare_all();
    @(posedge clk32);
    model_update();
    #1;
  endtask

  task automatic run_to_slot(input int s);
    while (m_slot != s) tick();
  endtask

  // Watchdog: the sequence is fixed-length, this only guards a stuck run.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] mask;
    int          cnt;

    reset = 1; flush = 0; de = 0; rez = 2'd0; din_valid = 0; din = '0;
    m_slot = 0; m_rez = 0; m_active = 0; m_load_left = 0; m_word = '0;
    m_underrun = 0; m_ucnt = 0;
    repeat (3) tick();
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    check("rst_dout", dout, 16'h0000);
    check("rst_load", load, 1'b0);
    check("rst_pix", pix_clk_en, 1'b0);
    check("rst_underrun", underrun, 1'b0);
    check("rst_count", fifo_count, 3'd0);
    reset = 0;

    // Idle low-rez cadence
    repeat (64) tick();
    run_to_slot(0);
    mask = '0;
    for (int i = 0; i < P; i++) begin
      mask[m_slot] = pix_clk_en;
      tick();
    end
    check("low_rez_pix_mask", mask, 16'h8888);
    check("idle_din_ready", din_ready, 1'b1);

    // Two words, display enabled before the last slot
    din_valid = 1; din = 16'h1234; tick();
    din = 16'h5678; tick();
    din_valid = 0;
    run_to_slot(14); de = 1; tick();
    run_to_slot(0);
    mask = '0;
    for (int i = 0; i < P; i++) begin
      mask[m_slot] = load;
      if (m_slot == 2) check("first_word", dout, 16'h1234);
      tick();
    end
    check("load_mask", mask, 16'h001E);
    check("second_word_at_slot0", dout, 16'h5678);
    tick();
    check("second_load", load, 1'b1);

    // Empty FIFO at a load slot
    run_to_slot(0);
    check("underrun_before", underrun, 1'b0);
    tick();
    check("underrun_set", underrun, 1'b1);
    check("skip_no_load", load, 1'b0);
`ifdef SHIFTER_LOAD_SCHED_UNDERRUN_CNT_EN
    check("underrun_cnt_1", underrun_cnt, 8'd1);
`endif

    // Fill the FIFO with din_valid held
    for (int i = 0; i < 6; i++) begin
      din_valid = 1;
      din = (i < 4) ? 16'hA000 + 16'(i) : 16'hBEEF;
      tick();
    end
    check("full_count", fifo_count, 3'd4);
    check("full_not_ready", din_ready, 1'b0);
    check("underrun_sticky", underrun, 1'b1);
    run_to_slot(0); tick();
    check("after_pop_count", fifo_count, 3'd3);
    check("after_pop_ready", din_ready, 1'b1);
    tick();
    check("refill_count", fifo_count, 3'd4);
    check("refill_not_ready", din_ready, 1'b0);
    check("fill_load", load, 1'b1);
    check("fill_word", dout, 16'hA000);

    // Flush in the middle of a load pulse
    flush = 1; tick();
    flush = 0; din_valid = 0;
    check("flush_load", load, 1'b0);
    check("flush_state", 32'(state_dbg), 32'(ST_IDLE));
    check("flush_count", fifo_count, 3'd0);
    check("flush_underrun", underrun, 1'b0);
    check("flush_ready", din_ready, 1'b1);

    // Resolution change mid-period takes effect at the next slot 0
    de = 0;
    run_to_slot(5); rez = 2'd2; tick();
    run_to_slot(7);
    check("rez_hold_s7", pix_clk_en, 1'b1);
    tick();
    check("rez_hold_s8", pix_clk_en, 1'b0);
    run_to_slot(14);
    check("rez_hold_s14", pix_clk_en, 1'b0);
    run_to_slot(0);
    cnt = 0;
    for (int i = 0; i < P; i++) begin
      if (pix_clk_en) cnt++;
      tick();
    end
    check("high_rez_count", cnt, 16);

    // Simultaneous push and pop keeps the count
    rez = 2'd0;
    din_valid = 1; din = 16'hC001; tick();
    din = 16'hC002; tick();
    din_valid = 0;
    run_to_slot(14); de = 1; tick();
    run_to_slot(0);
    din_valid = 1; din = 16'hC003; tick();
    din_valid = 0;
    check("push_pop_count", fifo_count, 3'd2);
    check("push_pop_word", dout, 16'hC001);

    // Flush beats a same-cycle push
    flush = 1; din_valid = 1; din = 16'hDEAD; tick();
    flush = 0; din_valid = 0;
    check("flush_vs_push", fifo_count, 3'd0);

    // A word pushed into an empty FIFO at slot 0 is not popped that cycle
    run_to_slot(0);
    din_valid = 1; din = 16'hC00F; tick();
    din_valid = 0;
    check("late_push_count", fifo_count, 3'd1);
    check("late_push_underrun", underrun, 1'b1);
    check("late_push_no_load", load, 1'b0);
    run_to_slot(0); tick(); tick();
    check("late_word_load", load, 1'b1);
    check("late_word", dout, 16'hC00F);

    // Reset during a load pulse
    de = 0;
    reset = 1; tick();
    reset = 0;
    check("mid_reset_load", load, 1'b0);
    check("mid_reset_state", 32'(state_dbg), 32'(ST_IDLE));
    check("mid_reset_dout", dout, 16'h0000);
    mask = '0;
    for (int i = 0; i < 2 * P; i++) begin
      mask[0] = mask[0] | load;
      tick();
    end
    check("no_partial_pulse", mask, 16'h0000);

    // Random traffic
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 7) == 0) de = ~de;
      if ($urandom_range(0, 31) == 0) rez = 2'($urandom_range(0, 3));
      din_valid = ($urandom_range(0, 11) == 0);
      din       = 16'($urandom);
      flush     = ($urandom_range(0, 99) == 0);
      reset     = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 0; flush = 0; din_valid = 0;
    tick();

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
